bus_controller: RTL and testbench

- Instruction sequencer for the 16-bit CPU datapath.
- Latches an instruction word from din and steps through T-states.
- Drives the bus-select controls (r_out, din_en, gout) and the register load enables (r_in, a_in, g_in) plus alu_op.
- Pulses done when the instruction retires. Sits beside the bus multiplexer, register file, A/G registers and ALU.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/reg_decoder.sv | 20 ++
 rtl/bus_controller.sv | 113 +++++++++++
 tb/tb_bus_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU datapath: opcodes, sequencer states, field widths.
package cpu_pkg;

  localparam int REG_SEL_W = 3;
  localparam int NREGS     = 8;
  localparam int ALU_OP_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  localparam logic [ALU_OP_W-1:0] OP_MV  = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_MVI = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [ALU_OP_W-1:0] OP_NOP = 3'b111;

  // ALU ops take the three-state A/G path; everything else retires in T1.
  function automatic logic is_alu_op(input logic [ALU_OP_W-1:0] op);
    return (op != OP_MV) && (op != OP_MVI) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/reg_decoder.sv
// 3-to-8 one-hot decoder with enable; produces the register-file load strobes.
module reg_decoder
  import cpu_pkg::*;
(
  input  logic                 en,
  input  logic [REG_SEL_W-1:0] sel,
  output logic [NREGS-1:0]     onehot
);

  // Exactly one bit when enabled, all zero otherwise.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/bus_controller.sv
// Instruction sequencer: latches an instruction from din and walks T1..T3,
// decoding bus-select and load-enable controls from the current state and IR.
module bus_controller
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DATA_W-1:0]    din,
  output logic                 ir_in,
  output logic [REG_SEL_W-1:0] r_out,
  output logic                 din_en,
  output logic                 gout,
  output logic [NREGS-1:0]     r_in,
  output logic                 a_in,
  output logic                 g_in,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 busy,
  output logic                 done
);

  state_t         state_r;
  logic [8:0]     ir_r;
  logic           dec_en_s;
  logic [2:0]     opcode_s;
  logic [2:0]     rx_s;
  logic [2:0]     ry_s;
  logic           unused_din_s;

  assign opcode_s     = ir_r[8:6];
  assign rx_s         = ir_r[5:3];
  assign ry_s         = ir_r[2:0];
  assign unused_din_s = ^din[DATA_W-1:9];

  // State sequencing and IR capture; reset abandons any in-flight instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      ir_r    <= 9'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (run) begin
            ir_r    <= din[8:0];
            state_r <= S_T1;
          end
        end
        S_T1:    state_r <= is_alu_op(opcode_s) ? S_T2 : S_IDLE;
        S_T2:    state_r <= S_T3;
        S_T3:    state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Control decode; async reset forces IDLE so everything but ir_in drops at once.
  always_comb begin
    ir_in    = 1'b0;
    r_out    = 3'b000;
    din_en   = 1'b0;
    gout     = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    alu_op   = 3'b000;
    done     = 1'b0;
    dec_en_s = 1'b0;
    busy     = (state_r != S_IDLE);
    case (state_r)
      S_IDLE: ir_in = run;
      S_T1: begin
        case (opcode_s)
          OP_MV: begin
            r_out    = ry_s;
            dec_en_s = 1'b1;
            done     = 1'b1;
          end
          OP_MVI: begin
            din_en   = 1'b1;
            dec_en_s = 1'b1;
            done     = 1'b1;
          end
          OP_NOP: done = 1'b1;
          default: begin
            r_out = rx_s;
            a_in  = 1'b1;
          end
        endcase
      end
      S_T2: begin
        r_out  = ry_s;
        g_in   = 1'b1;
        alu_op = opcode_s;
      end
      S_T3: begin
        gout     = 1'b1;
        dec_en_s = 1'b1;
        done     = 1'b1;
      end
      default: begin
        ir_in = 1'b0;
      end
    endcase
  end

  reg_decoder u_reg_decoder (
    .en     (dec_en_s),
    .sel    (rx_s),
    .onehot (r_in)
  );

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed instructions, reset abort,
// then randomized instruction streams against a cycle-schedule reference model.
module tb_bus_controller;

  logic        clock;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        ir_in;
  logic [2:0]  r_out;
  logic        din_en;
  logic        gout;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic [2:0]  alu_op;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  bus_controller #(.DATA_W(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .din    (din),
    .ir_in  (ir_in),
    .r_out  (r_out),
    .din_en (din_en),
    .gout   (gout),
    .r_in   (r_in),
    .a_in   (a_in),
    .g_in   (g_in),
    .alu_op (alu_op),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output bundle: {ir_in, r_out, din_en, gout, r_in, a_in, g_in, alu_op, busy, done}
  logic [20:0] obs_v;
  assign obs_v = {ir_in, r_out, din_en, gout, r_in, a_in, g_in, alu_op, busy, done};

  // Reference: expected outputs in cycle c of an instruction (c = 0 is the IDLE issue cycle).
  function automatic logic [20:0] model(input logic [2:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry, input int c, input logic run_v);
    logic       alu;
    int         lat;
    logic       e_ir, e_den, e_gout, e_a, e_g, e_busy, e_done;
    logic [2:0] e_rout, e_aop;
    logic [7:0] e_rin;
    alu    = (op >= 3'd2) && (op <= 3'd6);
    lat    = alu ? 3 : 1;
    e_ir   = (c == 0) ? run_v : 1'b0;
    e_busy = (c != 0);
    e_done = (c == lat);
    e_rin  = ((c == lat) && (op != 3'd7)) ? (8'd1 << rx) : 8'd0;
    e_den  = (op == 3'd1) && (c == 1);
    e_gout = alu && (c == 3);
    e_a    = alu && (c == 1);
    e_g    = alu && (c == 2);
    e_aop  = (alu && (c == 2)) ? op : 3'd0;
    if (c == 1 && op == 3'd0)  e_rout = ry;
    else if (c == 1 && alu)    e_rout = rx;
    else if (c == 2 && alu)    e_rout = ry;
    else                       e_rout = 3'd0;
    return {e_ir, e_rout, e_den, e_gout, e_rin, e_a, e_g, e_aop, e_busy, e_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic invariants(input string tag);
    check({tag, "_onehot0"}, {31'd0, $onehot0(r_in)}, 32'd1);
    check({tag, "_bus_excl"}, {31'd0, din_en & gout}, 32'd0);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clock);
    run = 1'b0;
    din = 16'($urandom);
    #1;
    check(tag, {11'd0, obs_v}, {11'd0, model(3'd0, 3'd0, 3'd0, 0, 1'b0)});
  endtask

  // Issue one instruction; abort_at > 0 applies reset mid-cycle in that T-state.
  task automatic do_instr(input string tag, input logic [2:0] op, input logic [2:0] rx,
                          input logic [2:0] ry, input logic hold, input logic [15:0] imm,
                          input int abort_at);
    int lat;
    lat = ((op >= 3'd2) && (op <= 3'd6)) ? 3 : 1;
    @(negedge clock);
    run = 1'b1;
    din = {7'($urandom), op, rx, ry};
    #1;
    check({tag, "_issue"}, {11'd0, obs_v}, {11'd0, model(op, rx, ry, 0, 1'b1)});
    for (int c = 1; c <= lat; c++) begin
      @(negedge clock);
      run = hold ? 1'b1 : 1'($urandom);
      din = (c == 1) ? imm : 16'($urandom);
      #1;
      check($sformatf("%s_t%0d", tag, c), {11'd0, obs_v}, {11'd0, model(op, rx, ry, c, run)});
      invariants(tag);
      if (c == abort_at) begin
        #1 reset = 1'b1;
        #1;
        check({tag, "_async_rst"}, {11'd0, obs_v}, {11'd0, model(op, rx, ry, 0, run)});
        @(negedge clock);
        reset = 1'b0;
        run = 1'b0;
        for (int k = 0; k < 3; k++) idle_check({tag, "_after_rst"});
        return;
      end
    end
  endtask

  initial begin
    logic [2:0] op, rx, ry;
    logic       hold;
    reset = 1'b1;
    run   = 1'b0;
    din   = 16'd0;
    #2;
    check("rst_outputs", {11'd0, obs_v}, 32'd0);
    run = 1'b1;
    #1;
    check("rst_ir_in_follows_run", {31'd0, ir_in}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    run = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    idle_check("idle_after_rst");

    do_instr("mv_r7_r0", 3'd0, 3'd7, 3'd0, 1'b0, 16'h0000, 0);
    idle_check("mv_retired");
    do_instr("mvi_r1", 3'd1, 3'd1, 3'd0, 1'b0, 16'h1234, 0);
    idle_check("mvi_retired");
    do_instr("add_r2_r3", 3'd2, 3'd2, 3'd3, 1'b0, 16'h0000, 0);
    idle_check("add_retired");
    do_instr("add_abort", 3'd2, 3'd2, 3'd3, 1'b0, 16'h0000, 2);
    do_instr("add_after_abort", 3'd2, 3'd5, 3'd6, 1'b0, 16'h0000, 0);
    do_instr("sub_r1_r1_a", 3'd3, 3'd1, 3'd1, 1'b1, 16'h0000, 0);
    do_instr("sub_r1_r1_b", 3'd3, 3'd1, 3'd1, 1'b1, 16'h0000, 0);
    do_instr("nop", 3'd7, 3'd0, 3'd0, 1'b0, 16'h0000, 0);
    idle_check("nop_retired");

    for (int i = 0; i < 60; i++) begin
      op   = 3'($urandom);
      rx   = 3'($urandom);
      ry   = 3'($urandom);
      hold = 1'($urandom);
      do_instr($sformatf("rnd%0d", i), op, rx, ry, hold, 16'($urandom), 0);
      if (!hold) idle_check($sformatf("rnd%0d_idle", i));
    end

    idle_check("final_idle");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
